// File: rtl/mux_arbiter.sv
// -----------------------------------------------------------------------------
// mux_arbiter
//
// Two-source round-robin arbiter with a registered output stage. Sources A and
// B present valid/data (req_x/data_x) and are accepted when their grant
// (gnt_x) is high in the same cycle. The accepted word is loaded into a single
// output register (out_valid/out_data) that drains under out_ready
// back-pressure.
//
// Fairness: while both sources request, a granted source keeps the grant for
// at most HOLD consecutive transfers before the grant moves to the other
// source. When the other source is idle, the grant persists indefinitely and
// the hold counter saturates. From IDLE with both sources requesting, the grant
// goes to the source that was not granted most recently.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_a      in   source A valid
//   data_a     in   source A data        [WIDTH-1:0]
//   req_b      in   source B valid
//   data_b     in   source B data        [WIDTH-1:0]
//   out_ready  in   downstream accepts out_data
//   gnt_a      out  source A ready (combinational)
//   gnt_b      out  source B ready (combinational)
//   sel        out  downstream mux select, 0 = A, 1 = B (registered state)
//   out_valid  out  out_data holds a word not yet taken
//   out_data   out  registered selected data [WIDTH-1:0]
//
// Parameters
//   WIDTH  data width (default 8)
//   HOLD   max consecutive transfers per grant under contention, 1..255
// -----------------------------------------------------------------------------
module mux_arbiter #(
  parameter int WIDTH = 8,
  parameter int HOLD  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  input  logic             out_ready,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_e;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  // Last transfer index within a grant; the counter never passes this value.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

  state_e           state_q, state_d;
  src_e             last_q, last_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic space;
  logic xfer_a;
  logic xfer_b;
  logic hold_at_limit;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  // The output register can take a new word when it is empty or being drained
  // this cycle. Grants depend only on registered state and this space term, so
  // there is no combinational path from req_x to gnt_x.
  always_comb begin
    space         = !out_valid_q || out_ready;
    gnt_a         = (state_q == GNT_A) && space;
    gnt_b         = (state_q == GNT_B) && space;
    xfer_a        = req_a && gnt_a;
    xfer_b        = req_b && gnt_b;
    hold_at_limit = (hold_cnt_q == HOLD_LAST);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned in this block gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;

    unique case (state_q)
      IDLE: begin
        if (req_a && req_b) begin
          // Contention from idle: favour the source that did not go last.
          state_d = (last_q == SRC_A) ? GNT_B : GNT_A;
        end else if (req_a) begin
          state_d = GNT_A;
        end else if (req_b) begin
          state_d = GNT_B;
        end
      end

      GNT_A: begin
        // Dropping the request is honoured even while the output is stalled;
        // the hold-limit switch needs an actual transfer, so a stall blocks it.
        if (!req_a) begin
          state_d = req_b ? GNT_B : IDLE;
        end else if (xfer_a && hold_at_limit && req_b) begin
          state_d = GNT_B;
        end
      end

      GNT_B: begin
        if (!req_b) begin
          state_d = req_a ? GNT_A : IDLE;
        end else if (xfer_b && hold_at_limit && req_a) begin
          state_d = GNT_A;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Grant bookkeeping: last granted source and hold counter
  // ---------------------------------------------------------------------------
  always_comb begin
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;

    if ((state_d == GNT_A) && (state_q != GNT_A)) begin
      last_d = SRC_A;
    end else if ((state_d == GNT_B) && (state_q != GNT_B)) begin
      last_d = SRC_B;
    end

    // Counter restarts on any state change. Otherwise it counts transfers and
    // sticks at HOLD-1, so a lone requester keeps the grant and the first
    // transfer after the other side starts requesting hands the grant over.
    if (state_d != state_q) begin
      hold_cnt_d = '0;
    end else if ((xfer_a || xfer_b) && !hold_at_limit) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  // Data is captured only on a transfer, so a non-granted source's data and a
  // stalled source's data never reach out_data.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (xfer_a) begin
      out_valid_d = 1'b1;
      out_data_d  = data_a;
    end else if (xfer_b) begin
      out_valid_d = 1'b1;
      out_data_d  = data_b;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  // The data register is reset as well: an aborted word must not survive reset
  // and out_data reads back as zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= SRC_B;
      hold_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      hold_cnt_q  <= hold_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // sel comes straight from the state register, so it only moves on an edge.
  assign sel       = (state_q == GNT_B);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
